// File: rtl/rv32_exec_datapath_pkg.sv
// Shared constants for the RV32I execute datapath: widths, opcodes and ALU funct3 encodings.
// Define RV32E_EN to shrink the register file to 16 entries (index bit 4 ignored).
package rv32_exec_datapath_pkg;

  localparam int WORD_LENGTH = 32;
`ifdef RV32E_EN
  localparam int RF_REG_NUM = 16;
`else
  localparam int RF_REG_NUM = 32;
`endif
  localparam int RF_IDX_W = $clog2(RF_REG_NUM);

  localparam logic [6:0]  OPC_LUI    = 7'b0110111;
  localparam logic [6:0]  OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0]  OPC_OP     = 7'b0110011;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

  typedef enum logic [2:0] {
    F3_ADD  = 3'b000,
    F3_SLL  = 3'b001,
    F3_SLT  = 3'b010,
    F3_SLTU = 3'b011,
    F3_XOR  = 3'b100,
    F3_SR   = 3'b101,
    F3_OR   = 3'b110,
    F3_AND  = 3'b111
  } alu_f3_e;

endpackage

// File: rtl/rv32_regfile.sv
// Architectural register file: one write port, three combinational read ports (rs1, rs2, debug).
// Under RV32E_EN only the low index bits are decoded, so x17 aliases x1.
module rv32_regfile
  import rv32_exec_datapath_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   we,
  input  logic [4:0]             waddr,
  input  logic [WORD_LENGTH-1:0] wdata,
  input  logic [4:0]             raddr1,
  input  logic [4:0]             raddr2,
  input  logic [4:0]             dbg_addr,
  output logic [WORD_LENGTH-1:0] rdata1,
  output logic [WORD_LENGTH-1:0] rdata2,
  output logic [WORD_LENGTH-1:0] dbg_data
);

  logic [WORD_LENGTH-1:0] regs_r [RF_REG_NUM];
  logic [RF_IDX_W-1:0]    widx_s;
  logic [RF_IDX_W-1:0]    ridx1_s;
  logic [RF_IDX_W-1:0]    ridx2_s;
  logic [RF_IDX_W-1:0]    didx_s;

  assign widx_s  = waddr[RF_IDX_W-1:0];
  assign ridx1_s = raddr1[RF_IDX_W-1:0];
  assign ridx2_s = raddr2[RF_IDX_W-1:0];
  assign didx_s  = dbg_addr[RF_IDX_W-1:0];

  // Register update: reset clears everything and wins over write-back; x0 is never written.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RF_REG_NUM; i++) begin
        regs_r[i] <= '0;
      end
    end else if (we && (widx_s != '0)) begin
      regs_r[widx_s] <= wdata;
    end
  end

  // Combinational reads; index 0 is hardwired to zero.
  always_comb begin
    rdata1   = (ridx1_s == '0) ? '0 : regs_r[ridx1_s];
    rdata2   = (ridx2_s == '0) ? '0 : regs_r[ridx2_s];
    dbg_data = (didx_s  == '0) ? '0 : regs_r[didx_s];
  end

endmodule

// File: rtl/rv32_exec_datapath.sv
// Single-cycle RV32I execute datapath: decode, register file and ALU with write-back at the next edge.
// Define RV32E_EN for the 16-register variant.
module rv32_exec_datapath
  import rv32_exec_datapath_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [31:0]            inst,
  output logic                   wb_en,
  output logic [4:0]             wb_addr,
  output logic [WORD_LENGTH-1:0] wb_data,
  output logic                   ebreak,
  input  logic [4:0]             dbg_addr,
  output logic [WORD_LENGTH-1:0] dbg_data
);

  logic [6:0]             opcode_s;
  logic [4:0]             rd_s;
  logic [4:0]             rs1_s;
  logic [4:0]             rs2_s;
  alu_f3_e                funct3_s;
  logic                   funct7_b5_s;
  logic [WORD_LENGTH-1:0] imm_i_s;
  logic [WORD_LENGTH-1:0] imm_u_s;
  logic [WORD_LENGTH-1:0] rs1_data_s;
  logic [WORD_LENGTH-1:0] rs2_data_s;
  logic [WORD_LENGTH-1:0] op2_s;
  logic [4:0]             shamt_s;
  logic [WORD_LENGTH-1:0] alu_res_s;
  logic                   wb_en_s;
  logic [WORD_LENGTH-1:0] wb_data_s;

  assign opcode_s    = inst[6:0];
  assign rd_s        = inst[11:7];
  assign funct3_s    = alu_f3_e'(inst[14:12]);
  assign rs1_s       = inst[19:15];
  assign rs2_s       = inst[24:20];
  assign funct7_b5_s = inst[30];
  assign imm_i_s     = {{20{inst[31]}}, inst[31:20]};
  assign imm_u_s     = {inst[31:12], 12'b0};

  rv32_regfile u_regfile (
    .clk      (clk),
    .rst      (rst),
    .we       (wb_en_s),
    .waddr    (rd_s),
    .wdata    (wb_data_s),
    .raddr1   (rs1_s),
    .raddr2   (rs2_s),
    .dbg_addr (dbg_addr),
    .rdata1   (rs1_data_s),
    .rdata2   (rs2_data_s),
    .dbg_data (dbg_data)
  );

  assign op2_s   = (opcode_s == OPC_OP_IMM) ? imm_i_s : rs2_data_s;
  assign shamt_s = op2_s[4:0];

  // Integer ALU; funct7[5] only selects sub for register-register ops, but selects sra for both forms.
  always_comb begin
    alu_res_s = '0;
    case (funct3_s)
      F3_ADD: begin
        if ((opcode_s == OPC_OP) && funct7_b5_s) begin
          alu_res_s = rs1_data_s - op2_s;
        end else begin
          alu_res_s = rs1_data_s + op2_s;
        end
      end
      F3_SLL:  alu_res_s = rs1_data_s << shamt_s;
      F3_SLT:  alu_res_s = {{(WORD_LENGTH-1){1'b0}}, ($signed(rs1_data_s) < $signed(op2_s))};
      F3_SLTU: alu_res_s = {{(WORD_LENGTH-1){1'b0}}, (rs1_data_s < op2_s)};
      F3_XOR:  alu_res_s = rs1_data_s ^ op2_s;
      F3_SR: begin
        if (funct7_b5_s) begin
          alu_res_s = $unsigned($signed(rs1_data_s) >>> shamt_s);
        end else begin
          alu_res_s = rs1_data_s >> shamt_s;
        end
      end
      F3_OR:   alu_res_s = rs1_data_s | op2_s;
      F3_AND:  alu_res_s = rs1_data_s & op2_s;
      default: alu_res_s = '0;
    endcase
  end

  // Write-back selection by opcode; everything else leaves the register file untouched.
  always_comb begin
    wb_en_s   = 1'b0;
    wb_data_s = '0;
    case (opcode_s)
      OPC_LUI: begin
        wb_en_s   = 1'b1;
        wb_data_s = imm_u_s;
      end
      OPC_OP_IMM, OPC_OP: begin
        wb_en_s   = 1'b1;
        wb_data_s = alu_res_s;
      end
      default: begin
        wb_en_s   = 1'b0;
        wb_data_s = '0;
      end
    endcase
  end

  assign wb_en   = wb_en_s;
  assign wb_addr = rd_s;
  assign wb_data = wb_data_s;
  assign ebreak  = (inst == INST_EBREAK);

endmodule

// File: tb/tb_rv32_exec_datapath.sv
// Directed self-checking bench for rv32_exec_datapath with hand-encoded instructions and results.
module tb_rv32_exec_datapath;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        ebreak;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;

  int pass_cnt = 0;
  int total_cnt = 0;

  rv32_exec_datapath dut (
    .clk      (clk),
    .rst      (rst),
    .inst     (inst),
    .wb_en    (wb_en),
    .wb_addr  (wb_addr),
    .wb_data  (wb_data),
    .ebreak   (ebreak),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] v);
    inst = v;
    #1;
  endtask

  task automatic peek(input string tag, input logic [4:0] a, input logic [31:0] exp);
    dbg_addr = a;
    #1;
    chk(tag, dbg_data, exp);
  endtask

  initial begin
    rst = 1'b1;
    inst = 32'h0000_0000;
    dbg_addr = 5'd1;
    tick();
    tick();
    // Outputs stay combinational in reset: addi sees rs1 = 0
    drive(32'h0050_0093);
    chk("rst_wb_data", wb_data, 32'h0000_0005);
    chk("rst_x1", dbg_data, 32'h0000_0000);
    rst = 1'b0;

    // addi x1,x0,5
    drive(32'h0050_0093);
    chk("addi_wb_en", {31'b0, wb_en}, 32'h1);
    chk("addi_wb_addr", {27'b0, wb_addr}, 32'h1);
    chk("addi_wb_data", wb_data, 32'h0000_0005);
    chk("addi_ebreak", {31'b0, ebreak}, 32'h0);
    tick();
    peek("x1_after_addi", 5'd1, 32'h0000_0005);

    // lui x2,0x12345 then dependent addi x2,x2,-1
    drive(32'h1234_5137);
    chk("lui_wb_data", wb_data, 32'h1234_5000);
    chk("lui_wb_en", {31'b0, wb_en}, 32'h1);
    tick();
    drive(32'hFFF1_0113);
    chk("addi_neg_wb_data", wb_data, 32'h1234_4FFF);
    tick();
    peek("x2_value", 5'd2, 32'h1234_4FFF);

    // sub x3,x0,x1 ; srai x4,x3,1 ; srli x5,x3,28
    drive(32'h4010_01B3);
    chk("sub_wb_data", wb_data, 32'hFFFF_FFFB);
    tick();
    drive(32'h4011_D213);
    chk("srai_wb_data", wb_data, 32'hFFFF_FFFD);
    tick();
    drive(32'h01C1_D293);
    chk("srli_wb_data", wb_data, 32'h0000_000F);
    tick();
    peek("x4_value", 5'd4, 32'hFFFF_FFFD);
    peek("x5_value", 5'd5, 32'h0000_000F);

    // slti / sltiu x3 against 1
    drive(32'h0011_A313);
    chk("slti_wb_data", wb_data, 32'h0000_0001);
    tick();
    drive(32'h0011_B393);
    chk("sltiu_wb_data", wb_data, 32'h0000_0000);
    tick();

    // Register-register ops
    drive(32'h0030_C433);
    chk("xor_wb_data", wb_data, 32'hFFFF_FFFE);
    drive(32'h0020_E4B3);
    chk("or_wb_data", wb_data, 32'h1234_4FFF);
    drive(32'h0021_F533);
    chk("and_wb_data", wb_data, 32'h1234_4FFB);
    drive(32'h0010_95B3);
    chk("sll_wb_data", wb_data, 32'h0000_00A0);
    drive(32'h0011_A633);
    chk("slt_wb_data", wb_data, 32'h0000_0001);
    drive(32'h0011_B6B3);
    chk("sltu_wb_data", wb_data, 32'h0000_0000);
    drive(32'h0011_8733);
    chk("add_wb_data", wb_data, 32'h0000_0000);
    tick();
    peek("x14_value", 5'd14, 32'h0000_0000);

    // addi x0,x0,7: wb_en follows opcode, x0 stays zero
    drive(32'h0070_0013);
    chk("x0_wb_en", {31'b0, wb_en}, 32'h1);
    chk("x0_wb_data", wb_data, 32'h0000_0007);
    tick();
    peek("x0_value", 5'd0, 32'h0000_0000);

    // sw x1,1(x2): rd field = 1 but store never writes back
    drive(32'h0011_20A3);
    chk("store_wb_en", {31'b0, wb_en}, 32'h0);
    chk("store_wb_data", wb_data, 32'h0000_0000);
    tick();
    peek("x1_after_store", 5'd1, 32'h0000_0005);

    // ebreak
    drive(32'h0010_0073);
    chk("ebreak_flag", {31'b0, ebreak}, 32'h1);
    chk("ebreak_wb_en", {31'b0, wb_en}, 32'h0);
    tick();

    // Reset mid-run has priority over addi x15,x0,9
    rst = 1'b1;
    drive(32'h0090_0793);
    tick();
    rst = 1'b0;
    drive(32'h0000_0000);
    peek("x1_after_rst", 5'd1, 32'h0000_0000);
    peek("x3_after_rst", 5'd3, 32'h0000_0000);
    peek("x15_after_rst", 5'd15, 32'h0000_0000);
    chk("illegal_wb_en", {31'b0, wb_en}, 32'h0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/rv32_exec_datapath.md
# rv32_exec_datapath

Single-cycle RV32I integer execute datapath for the NPC core. It combines instruction decode, a general-purpose register file and an integer ALU. It receives one 32-bit instruction per cycle from the fetch/PC logic. It reads rs1/rs2 combinationally, computes the result and writes it back to rd on the next rising clock edge.

## Interface
- `WORD_LENGTH`, 32: datapath and register width.
- `RF_REG_NUM`, 32 (16 when `RV32E_EN` is defined): number of architectural registers.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `inst` input 32: current instruction, held stable for the whole cycle.
- `wb_en` output 1: register write-back occurs at the coming edge.
- `wb_addr` output 5: destination register index (inst[11:7]).
- `wb_data` output WORD_LENGTH: ALU result to be written.
- `ebreak` output 1: high while `inst == 32'h00100073`.
- `dbg_addr` input 5: debug read index.
- `dbg_data` output WORD_LENGTH: combinational read of register `dbg_addr`; x0 reads 0.

## Operation
- Decode fields:
  - opcode = inst[6:0]
  - rd = inst[11:7]
  - funct3 = inst[14:12]
  - rs1 = inst[19:15]
  - rs2 = inst[24:20]
  - funct7 = inst[31:25]
- Immediates, each sign-extended to 32 bits:
  - immI = inst[31:20]
  - immS = {inst[31:25], inst[11:7]}
  - immB = {inst[31], inst[7], inst[30:25], inst[11:8], 0}
  - immU = {inst[31:12], 12'b0}
  - immJ = {inst[31], inst[19:12], inst[20], inst[30:21], 0}
- Only immI and immU are consumed in this block.
- Write enable is asserted for LUI (0110111), OP-IMM (0010011) and OP (0110011).
  - All other opcodes: `wb_en`=0 and `wb_data`=0.
- ALU operand 2 is immI for OP-IMM and rs2 data otherwise.
- ALU operation, selected by funct3:
  - 000: OP-IMM → add. OP → sub when funct7[5]=1, else add.
  - 001: sll.
  - 010: slt (signed).
  - 011: sltu.
  - 100: xor.
  - 101: sra when funct7[5]=1, else srl.
  - 110: or.
  - 111: and.
- Shift amount is operand2[4:0].
- LUI: result = immU; rs1 is ignored.
- Register x0 always reads 0. Writes to x0 are discarded, but `wb_en` still reflects the opcode.
- Write-back: at a rising edge with `wb_en`=1 and rd≠0, RF[rd] ← `wb_data`.

## Timing
- Decode, register read, ALU and all outputs are purely combinational from `inst` and RF state. There is zero latency within a cycle.
- A write becomes visible to reads in the following cycle. There is no write-to-read bypass within the same cycle.
- Reset:
  - While `rst`=1 at an edge, all registers clear to 0 and no write occurs (reset has priority over write-back).
  - The outputs stay combinational during reset. With all registers zero, `wb_data` reflects operands of 0.
- Back-to-back dependent instructions: the second instruction reads the value written at the edge between them.

## Configuration
- `RV32E_EN` undefined: 32 registers; rs1/rs2/rd use all 5 bits.
- `RV32E_EN` defined:
  - `RF_REG_NUM`=16.
  - Index bit 4 is ignored for reads, writes and `dbg_addr`, so x17 aliases x1.

## Structure
- Shared package contains:
  - word width and register count constants;
  - opcode constants (LUI, OP_IMM, OP, EBREAK encoding);
  - funct3 ALU encodings.
- Natural sub-modules:
  - `rv32_regfile`: 1 write port, 3 combinational read ports (rs1, rs2, debug).
  - Decode and ALU are plain combinational logic in the top module.

## Test plan
- Reset, then `addi x1,x0,5` (0x00500093) → `wb_en`=1, `wb_addr`=1, `wb_data`=5. Next cycle `dbg_addr`=1 reads 5.
- `lui x2,0x12345` (0x12345137) → `wb_data`=0x12345000. Then `addi x2,x2,-1` → x2=0x12344FFF.
- With x1=5, `sub x3,x0,x1` → x3=0xFFFFFFFB. Then `srai x4,x3,1` → 0xFFFFFFFD, and `srli x5,x3,28` → 0xF.
- `slti` vs `sltiu`, with x3=0xFFFFFFFB and imm=1 → slti=1, sltiu=0.
- `addi x0,x0,7` → x0 still reads 0. Store opcode 0100011 → `wb_en`=0 and no register changes.
- 0x00100073 → `ebreak`=1 and `wb_en`=0. Assert `rst` mid-run → all registers read 0 next cycle.
